// File: rtl/pixel_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pixel_frame_buffer
// Description : Two-bank (ping-pong) frame buffer for a raster stream of
//               grey-level pixels.
//
//               Each accepted pixel is quantised to PIX_BITS and written into
//               the write bank. A reader fetches pixels from the other bank
//               by (x, y) coordinate. When a frame is complete, the banks swap
//               only while rd_lock is low, so a frame that is being scanned
//               out is never torn.
//
// Ports       : clk          - single clock, rising edge
//               rst_n        - asynchronous active-low reset
//               in_valid     - input pixel valid
//               in_data      - input grey level (IN_BITS)
//               in_sof       - current input pixel is first of frame
//               in_ready     - pixel accepted when in_valid & in_ready
//               quant_mode   - 0: three-level, 1: truncate to the MSBs
//               rd_lock      - reader busy on the read bank; blocks a swap
//               rd_en        - read request for (rd_x, rd_y)
//               rd_x, rd_y   - read coordinate (32 bit)
//               rd_valid     - rd_data / rd_oob valid (one cycle after rd_en)
//               rd_data      - pixel from the read bank (PIX_BITS)
//               rd_oob       - last request was outside the frame
//               frame_ready  - read bank holds a complete frame
//               swap_pulse   - one-cycle strobe after each bank swap
//               sof_err      - one-cycle strobe when a partial frame is dropped
//
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_frame_buffer #(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int IN_BITS      = 8,
    parameter int PIX_BITS     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [IN_BITS-1:0]  in_data,
    input  logic                in_sof,
    output logic                in_ready,
    input  logic                quant_mode,
    input  logic                rd_lock,
    input  logic                rd_en,
    input  logic [31:0]         rd_x,
    input  logic [31:0]         rd_y,
    output logic                rd_valid,
    output logic [PIX_BITS-1:0] rd_data,
    output logic                rd_oob,
    output logic                frame_ready,
    output logic                swap_pulse,
    output logic                sof_err
);

    // ------------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------------
    localparam int c_DEPTH = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int c_AW    = (c_DEPTH > 1)      ? $clog2(c_DEPTH)      : 1;
    localparam int c_XW    = (FRAME_WIDTH > 1)  ? $clog2(FRAME_WIDTH)  : 1;
    localparam int c_YW    = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;

    localparam logic [c_XW-1:0] c_X_LAST = c_XW'(FRAME_WIDTH - 1);
    localparam logic [c_YW-1:0] c_Y_LAST = c_YW'(FRAME_HEIGHT - 1);

    // FSM encoding
    localparam logic [0:0] c_S_FILL = 1'b0;
    localparam logic [0:0] c_S_PEND = 1'b1;

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic                w_swap;

    logic                r_run;          // low during reset, high one edge after release
    logic                r_wr_bank;
    logic [c_XW-1:0]     r_wr_x;
    logic [c_YW-1:0]     r_wr_y;
    logic                r_frame_ready;
    logic                r_swap_pulse;
    logic                r_sof_err;

    logic                r_rd_valid;
    logic                r_rd_oob;
    logic                r_rd_use_ram;   // rd_data comes from RAM (else forced to 0)
    logic [PIX_BITS-1:0] r_ram_q;

    logic                w_accept;
    logic [PIX_BITS-1:0] w_q_data;
    logic [c_XW-1:0]     w_cur_x;
    logic [c_YW-1:0]     w_cur_y;
    logic                w_x_last;
    logic                w_y_last;
    logic                w_frame_end;
    logic [c_XW-1:0]     w_nxt_x;
    logic [c_YW-1:0]     w_nxt_y;
    logic [c_AW-1:0]     w_wr_addr;
    logic [c_AW-1:0]     w_rd_addr;
    logic                w_rd_oob;

    logic [PIX_BITS-1:0] r_mem0 [c_DEPTH];
    logic [PIX_BITS-1:0] r_mem1 [c_DEPTH];

    // ------------------------------------------------------------------------
    // Input handshake
    // ------------------------------------------------------------------------
    assign in_ready = r_run && (r_state == c_S_FILL);
    assign w_accept = in_valid && in_ready;

    // ------------------------------------------------------------------------
    // Quantiser
    //   mode 0: 0 -> 0, all ones -> all ones, anything else -> 1
    //   mode 1: keep the PIX_BITS most significant bits
    // ------------------------------------------------------------------------
    always_comb begin
        w_q_data = '0;
        if (quant_mode) begin
            w_q_data = in_data[IN_BITS-1 -: PIX_BITS];
        end else if (in_data == '0) begin
            w_q_data = '0;
        end else if (&in_data) begin
            w_q_data = '1;
        end else begin
            w_q_data = PIX_BITS'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Write position
    //   A start-of-frame pixel is placed at (0,0) regardless of where the
    //   counters were; the raster advance is then taken from that position,
    //   so the counters resume from the pixel after it.
    // ------------------------------------------------------------------------
    always_comb begin
        w_cur_x     = in_sof ? '0 : r_wr_x;
        w_cur_y     = in_sof ? '0 : r_wr_y;
        w_x_last    = (w_cur_x == c_X_LAST);
        w_y_last    = (w_cur_y == c_Y_LAST);
        w_frame_end = w_x_last && w_y_last;
        w_nxt_x     = w_x_last ? '0 : (w_cur_x + c_XW'(1));
        w_nxt_y     = w_cur_y;
        if (w_x_last) begin
            w_nxt_y = w_y_last ? '0 : (w_cur_y + c_YW'(1));
        end
    end

    assign w_wr_addr = (c_AW'(w_cur_y) * c_AW'(FRAME_WIDTH)) + c_AW'(w_cur_x);

    // ------------------------------------------------------------------------
    // Read address and range check (done on the full 32-bit coordinates so
    // large values never alias into the frame)
    // ------------------------------------------------------------------------
    assign w_rd_oob  = (rd_x >= 32'(FRAME_WIDTH)) || (rd_y >= 32'(FRAME_HEIGHT));
    assign w_rd_addr = (c_AW'(rd_y[c_YW-1:0]) * c_AW'(FRAME_WIDTH))
                     + c_AW'(rd_x[c_XW-1:0]);

    // ------------------------------------------------------------------------
    // Frame memory: two synchronous-read banks, no reset on the storage.
    // The read bank is always the one not being written; the bank select is
    // the pre-edge value, so a read issued in the swap cycle still sees the
    // old read bank.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept && !r_wr_bank) begin
            r_mem0[w_wr_addr] <= w_q_data;
        end
        if (w_accept && r_wr_bank) begin
            r_mem1[w_wr_addr] <= w_q_data;
        end
        if (rd_en && !w_rd_oob) begin
            r_ram_q <= r_wr_bank ? r_mem0[w_rd_addr] : r_mem1[w_rd_addr];
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state: FILL accepts pixels, PEND waits for the reader to
    // release the read bank before swapping.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_swap      = 1'b0;
        case (r_state)
            c_S_FILL: begin
                if (w_accept && w_frame_end) begin
                    w_state_nxt = c_S_PEND;
                end
            end
            c_S_PEND: begin
                if (!rd_lock) begin
                    w_swap      = 1'b1;
                    w_state_nxt = c_S_FILL;
                end
            end
            default: begin
                w_state_nxt = c_S_FILL;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Control and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_S_FILL;
            r_run         <= 1'b0;
            r_wr_bank     <= 1'b0;
            r_wr_x        <= '0;
            r_wr_y        <= '0;
            r_frame_ready <= 1'b0;
            r_swap_pulse  <= 1'b0;
            r_sof_err     <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_rd_oob      <= 1'b0;
            r_rd_use_ram  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_run        <= 1'b1;
            r_swap_pulse <= w_swap;
            r_sof_err    <= w_accept && in_sof && ((r_wr_x != '0) || (r_wr_y != '0));

            if (w_swap) begin
                r_wr_bank     <= ~r_wr_bank;
                r_frame_ready <= 1'b1;
            end

            // Frame end wraps both counters back to (0,0) via the advance logic.
            if (w_accept) begin
                r_wr_x <= w_nxt_x;
                r_wr_y <= w_nxt_y;
            end

            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_oob     <= w_rd_oob;
                r_rd_use_ram <= !w_rd_oob;
            end
        end
    end

    // rd_data is 0 after reset and after an out-of-range read; otherwise it
    // shows the RAM output register, which only loads on in-range reads and
    // therefore holds between requests.
    assign rd_data     = r_rd_use_ram ? r_ram_q : '0;
    assign rd_valid    = r_rd_valid;
    assign rd_oob      = r_rd_oob;
    assign frame_ready = r_frame_ready;
    assign swap_pulse  = r_swap_pulse;
    assign sof_err     = r_sof_err;

endmodule
`default_nettype wire

// File: tb/tb_pixel_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_frame_buffer
// Description : Self-checking bench for pixel_frame_buffer on a 4x3 frame.
//               Two instances share all inputs: PIX_BITS=2 and PIX_BITS=1.
//               A bank model tracks what each pixel should contain; read
//               expectations are queued when a read is issued and compared
//               when the result appears one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_frame_buffer;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_sof;
    logic        quant_mode;
    logic        rd_lock;
    logic        rd_en;
    logic [31:0] rd_x;
    logic [31:0] rd_y;

    logic        in_ready, rd_valid, rd_oob, frame_ready, swap_pulse, sof_err;
    logic [1:0]  rd_data;
    logic        in_ready1, rd_valid1, rd_oob1, frame_ready1, swap_pulse1, sof_err1;
    logic [0:0]  rd_data1;

    pixel_frame_buffer #(
        .FRAME_WIDTH (W),
        .FRAME_HEIGHT(H),
        .IN_BITS     (8),
        .PIX_BITS    (2)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof), .in_ready(in_ready),
        .quant_mode(quant_mode), .rd_lock(rd_lock),
        .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_oob(rd_oob),
        .frame_ready(frame_ready), .swap_pulse(swap_pulse), .sof_err(sof_err)
    );

    pixel_frame_buffer #(
        .FRAME_WIDTH (W),
        .FRAME_HEIGHT(H),
        .IN_BITS     (8),
        .PIX_BITS    (1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof), .in_ready(in_ready1),
        .quant_mode(quant_mode), .rd_lock(rd_lock),
        .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y),
        .rd_valid(rd_valid1), .rd_data(rd_data1), .rd_oob(rd_oob1),
        .frame_ready(frame_ready1), .swap_pulse(swap_pulse1), .sof_err(sof_err1)
    );

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    logic [1:0] mb2 [2][N];
    logic [0:0] mb1 [2][N];
    int         mwrb = 0;
    int         mx   = 0;
    int         my   = 0;
    logic [7:0] fdata [N];
    logic [1:0] last_d2;
    logic [0:0] last_d1;

    typedef struct {
        logic       oob;
        logic [1:0] d2;
        logic [0:0] d1;
    } rd_exp_t;

    rd_exp_t sb_q[$];

    function automatic logic [1:0] q2(input logic [7:0] d, input logic m);
        if (m)          return d[7:6];
        if (d == 8'h00) return 2'd0;
        if (d == 8'hFF) return 2'd3;
        return 2'd1;
    endfunction

    function automatic logic [0:0] q1(input logic [7:0] d, input logic m);
        if (m)          return d[7];
        if (d == 8'h00) return 1'b0;
        return 1'b1;
    endfunction

    // One clock; results of a read issued in the previous cycle are checked.
    task automatic cyc();
        rd_exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val("rd_valid", rd_valid, 1);
            check_val("rd_oob", rd_oob, e.oob);
            check_val("rd_data", rd_data, e.d2);
            check_val("rd_data_1b", rd_data1, e.d1);
            last_d2 = e.d2;
            last_d1 = e.d1;
        end
    endtask

    task automatic do_read(input logic [31:0] x, input logic [31:0] y);
        rd_exp_t e;
        int      idx;
        rd_en = 1'b1;
        rd_x  = x;
        rd_y  = y;
        e.oob = (x >= 32'(W)) || (y >= 32'(H));
        e.d2  = '0;
        e.d1  = '0;
        if (!e.oob) begin
            idx  = int'(y) * W + int'(x);
            e.d2 = mb2[1 - mwrb][idx];
            e.d1 = mb1[1 - mwrb][idx];
        end
        sb_q.push_back(e);
        cyc();
        rd_en = 1'b0;
    endtask

    // Read the whole read bank back-to-back, then confirm rd_valid drops
    // and rd_data holds.
    task automatic read_all();
        for (int i = 0; i < N; i++) begin
            do_read(32'(i % W), 32'(i / W));
        end
        cyc();
        check_val("rd_valid_idle", rd_valid, 0);
        check_val("rd_data_hold", rd_data, last_d2);
        check_val("rd_data_1b_hold", rd_data1, last_d1);
    endtask

    task automatic send(input logic [7:0] d, input logic sof, input logic mode);
        int   t;
        logic exp_err;
        t          = 0;
        in_valid   = 1'b1;
        in_data    = d;
        in_sof     = sof;
        quant_mode = mode;
        while (!in_ready && t < 100) begin
            cyc();
            t++;
        end
        if (!in_ready) check_val("in_ready_wait", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        exp_err  = sof && ((mx != 0) || (my != 0));
        if (sof) begin
            mx = 0;
            my = 0;
        end
        mb2[mwrb][my * W + mx] = q2(d, mode);
        mb1[mwrb][my * W + mx] = q1(d, mode);
        if (mx == W - 1) begin
            mx = 0;
            my = (my == H - 1) ? 0 : my + 1;
        end else begin
            mx++;
        end
        check_val("sof_err", sof_err, exp_err);
    endtask

    task automatic send_frame(input logic mode, input logic sof_first);
        for (int i = 0; i < N; i++) begin
            send(fdata[i], (i == 0) ? sof_first : 1'b0, mode);
        end
    endtask

    // Called one cycle after the last pixel was accepted (FSM in PEND).
    task automatic expect_swap();
        check_val("in_ready_pend", in_ready, 0);
        cyc();
        check_val("swap_pulse", swap_pulse, 1);
        check_val("frame_ready", frame_ready, 1);
        check_val("in_ready_after_swap", in_ready, 1);
        check_val("swap_pulse_1b", swap_pulse1, 1);
        mwrb = 1 - mwrb;
        cyc();
        check_val("swap_pulse_end", swap_pulse, 0);
    endtask

    task automatic random_frame();
        for (int i = 0; i < N; i++) fdata[i] = 8'($urandom_range(0, 255));
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_sof     = 1'b0;
        quant_mode = 1'b0;
        rd_lock    = 1'b0;
        rd_en      = 1'b0;
        rd_x       = '0;
        rd_y       = '0;
        last_d2    = '0;
        last_d1    = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_rd_valid", rd_valid, 0);
        check_val("rst_rd_data", rd_data, 0);
        check_val("rst_rd_oob", rd_oob, 0);
        check_val("rst_frame_ready", frame_ready, 0);
        check_val("rst_swap_pulse", swap_pulse, 0);
        check_val("rst_sof_err", sof_err, 0);
        rst_n = 1'b1;
        cyc();
        check_val("in_ready_after_rst", in_ready, 1);
        check_val("frame_ready_after_rst", frame_ready, 0);

        // Basic fill and readback, three-level mode
        fdata = '{8'd0, 8'd255, 8'd17, 8'd1, 8'd254, 8'd128,
                  8'd0, 8'd255, 8'd64, 8'd200, 8'd255, 8'd3};
        send_frame(1'b0, 1'b1);
        expect_swap();
        do_read(32'd1, 32'd0);
        check_val("basic_1_0", rd_data, 2'd3);
        do_read(32'd0, 32'd0);
        check_val("basic_0_0", rd_data, 2'd0);
        do_read(32'd2, 32'd0);
        check_val("basic_2_0", rd_data, 2'd1);
        read_all();

        // Truncate mode
        random_frame();
        fdata[0] = 8'hB7;
        fdata[1] = 8'h7F;
        send_frame(1'b1, 1'b1);
        expect_swap();
        do_read(32'd0, 32'd0);
        check_val("trunc_b7", rd_data, 2'b10);
        do_read(32'd1, 32'd0);
        check_val("trunc_7f_1b", rd_data1, 1'b0);
        read_all();

        random_frame();
        send_frame(1'b1, 1'b1);
        expect_swap();
        read_all();

        // Swap blocking: reader keeps the old frame while rd_lock is high
        rd_lock = 1'b1;
        random_frame();
        send_frame(1'b0, 1'b1);
        for (int i = 0; i < 50; i++) begin
            check_val("lock_in_ready", in_ready, 0);
            check_val("lock_no_swap", swap_pulse, 0);
            do_read(32'(i % W), 32'((i / W) % H));
        end
        rd_lock = 1'b0;
        expect_swap();
        read_all();

        // Out of range
        do_read(32'd4, 32'd0);
        do_read(32'd0, 32'd3);
        do_read(32'hFFFF_FFFF, 32'd0);
        check_val("oob_flag", rd_oob, 1);
        do_read(32'd3, 32'd2);
        cyc();

        // Mid-frame SOF: 5 pixels, then a SOF pixel, then 11 more
        random_frame();
        for (int i = 0; i < 5; i++) send(8'($urandom_range(1, 254)), 1'b0, 1'b0);
        send(8'hFF, 1'b1, 1'b0);
        for (int i = 1; i < N; i++) begin
            send(fdata[i], 1'b0, 1'b0);
            if (i == N - 2) check_val("sof_no_early_swap", in_ready, 1);
        end
        expect_swap();
        read_all();

        // Reset while PEND with frame_ready set
        rd_lock = 1'b1;
        for (int i = 0; i < N; i++) fdata[i] = (i % 2 == 0) ? 8'hFF : 8'h00;
        send_frame(1'b0, 1'b1);
        check_val("pend_in_ready", in_ready, 0);
        check_val("pend_frame_ready", frame_ready, 1);
        do_read(32'd1, 32'd0);
        @(posedge clk);
        #3;
        rst_n   = 1'b0;
        rd_lock = 1'b0;
        #1;
        check_val("arst_in_ready", in_ready, 0);
        check_val("arst_frame_ready", frame_ready, 0);
        check_val("arst_rd_valid", rd_valid, 0);
        check_val("arst_rd_data", rd_data, 0);
        check_val("arst_rd_oob", rd_oob, 0);
        check_val("arst_swap_pulse", swap_pulse, 0);
        check_val("arst_sof_err", sof_err, 0);
        // Model: bank select back to 0, counters to (0,0); RAM keeps contents,
        // so the read bank (bank 1) holds the frame written just before reset.
        mwrb = 0;
        mx   = 0;
        my   = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();
        check_val("post_rst_in_ready", in_ready, 1);
        check_val("post_rst_frame_ready", frame_ready, 0);
        read_all();
        random_frame();
        send_frame(1'b0, 1'b0);
        expect_swap();
        read_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/pixel_frame_buffer.md
# pixel_frame_buffer

Synchronous, parametrised successor to the static pixel lookup memory: accepts a raster stream of grey-level pixels, quantises each to `PIX_BITS` and stores it in a ping-pong (two-bank) frame buffer. The frame generator reads the completed bank by (x, y) coordinate while the next frame is written into the other bank. Bank swap is handshaked so that a frame being scanned out is never torn.

## Interface
- `FRAME_WIDTH`, 640: pixels per line.
- `FRAME_HEIGHT`, 480: lines per frame.
- `IN_BITS`, 8: input grey-level width.
- `PIX_BITS`, 2: stored pixel width, 1 ≤ `PIX_BITS` ≤ `IN_BITS`.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input pixel valid.
- `in_data` in `IN_BITS`: input grey level.
- `in_sof` in 1: qualifies the current input pixel as first of frame.
- `in_ready` out 1: input can be accepted; a transfer occurs when `in_valid & in_ready`.
- `quant_mode` in 1: 0 = three-level, 1 = truncate. Sampled per accepted pixel.
- `rd_lock` in 1: reader is scanning the read bank; blocks a swap.
- `rd_en` in 1: read request.
- `rd_x` in 32: read column.
- `rd_y` in 32: read row.
- `rd_valid` out 1: `rd_data` / `rd_oob` valid.
- `rd_data` out `PIX_BITS`: pixel from the read bank.
- `rd_oob` out 1: the request was out of range.
- `frame_ready` out 1: the read bank holds a complete frame.
- `swap_pulse` out 1: one-cycle strobe after each bank swap.
- `sof_err` out 1: one-cycle strobe when a partial frame is discarded.

## Operation
- **Storage:** two banks, each `FRAME_WIDTH*FRAME_HEIGHT` × `PIX_BITS`. Address = y*`FRAME_WIDTH` + x. `wr_bank` and `rd_bank` = !`wr_bank` are selected by a 1-bit register. Both banks are synchronous-read RAM.
- **Quantisation, mode 0:**
  - `in_data` = 0 → 0.
  - `in_data` = all ones → all ones.
  - Any other value → 1.
  - With `PIX_BITS`=1, the "other" case maps to 1.
- **Quantisation, mode 1:** `in_data[IN_BITS-1 -: PIX_BITS]`.
- **Write counters:** `wr_x` and `wr_y` advance in raster order on each accepted pixel. `wr_x` wraps at `FRAME_WIDTH`-1 and increments `wr_y`.
- **Start of frame:**
  - An accepted pixel with `in_sof`=1 is written at (0,0), and the counters resume from (1,0).
  - If the counters were not at (0,0), `sof_err` pulses next cycle; already-written pixels are simply overwritten.
  - An accepted pixel with `in_sof`=0 while the counters are at (0,0) is written normally; `in_sof` is not mandatory.
- **FSM FILL (reset state):**
  - `in_ready`=1.
  - When the pixel at (`FRAME_WIDTH`-1, `FRAME_HEIGHT`-1) is accepted → PEND, and the counters clear to (0,0).
- **FSM PEND:**
  - `in_ready`=0.
  - In any PEND cycle with `rd_lock`=0: at the closing edge `wr_bank` toggles, `frame_ready` sets, and the FSM returns to FILL. `swap_pulse`=1 for the following cycle.
  - With `rd_lock`=1, PEND holds indefinitely.
- **Reads:**
  - `rd_en` samples `rd_x`/`rd_y` against the current `rd_bank`.
  - If `rd_x` ≥ `FRAME_WIDTH` or `rd_y` ≥ `FRAME_HEIGHT`: `rd_data`=0, `rd_oob`=1, no RAM access.
  - Reads are allowed while `frame_ready`=0; `rd_data` is then undefined content but `rd_valid` still asserts.
- **Concurrent read and swap:** a read issued in the swap cycle uses the pre-swap `rd_bank`.

## Timing
- **Reset values:**
  - `in_ready`=0 while `rst_n`=0, and 1 from the first cycle after release.
  - `rd_valid`=0, `rd_data`=0, `rd_oob`=0.
  - `frame_ready`=0, `swap_pulse`=0, `sof_err`=0.
  - `wr_bank`=0, counters (0,0), FSM=FILL.
- **Reset mid-operation:** everything above is restored immediately. RAM contents are not cleared but are treated as invalid via `frame_ready`=0.
- **Write latency:** a pixel accepted at cycle n is readable from its bank at cycle n+1 (visible to reads only after a swap).
- **Read latency:** `rd_en` at cycle n → `rd_valid`, `rd_data`, `rd_oob` at n+1. Fully pipelined: one read per cycle. `rd_valid`=0 in cycles following `rd_en`=0, and `rd_data` holds its last value.
- **Swap timing:** last pixel accepted at n → PEND at n+1 → with `rd_lock`=0 at n+1, swap at the n+1/n+2 edge. At n+2: `swap_pulse`=1 and `in_ready`=1. The minimum inter-frame bubble is 1 cycle.
- **`rd_lock` timing:** `rd_lock` asserted in the same cycle the FSM enters PEND blocks that swap.
- **`in_valid` with `in_ready`=0:** ignored; the source must hold the data.

## Test plan
- **Basic fill and readback.** Params 4×3, `PIX_BITS`=2, mode 0. Stream 12 pixels {0,255,17,…}, `rd_lock`=0. Required: `swap_pulse` 2 cycles after the last pixel, `frame_ready`=1. Reading (1,0) gives 3; (0,0) gives 0; (2,0) gives 1, each with 1-cycle latency.
- **Truncate mode.** Mode 1, `in_data`=0xB7, `PIX_BITS`=2. Readback gives 2'b10. With `PIX_BITS`=1, 0x7F gives 0.
- **Swap blocking.** Hold `rd_lock`=1 through the end of frame. Required: `in_ready`=0 and no `swap_pulse` for 50 cycles; the read bank still returns the old frame. Deassert `rd_lock` → swap next edge, and the new data is visible.
- **Out of range.** `rd_en` with (4,0), (0,3) and (0xFFFFFFFF, 0) on 4×3. Required: `rd_oob`=1, `rd_data`=0, `rd_valid`=1 one cycle later.
- **Mid-frame SOF.** 5 pixels, then an `in_sof` pixel. Required: `sof_err` pulses once, and that pixel lands at (0,0). After 11 more pixels the swap occurs (12 total from SOF).
- **Reset mid-frame.** Pulse `rst_n` low during PEND with `frame_ready`=1. Required: all outputs return to reset values asynchronously, and the FSM is in FILL at (0,0) with `wr_bank`=0.
